// File: rtl/dm_dac_out_sequencer.sv
// Serializes DAC command words MSB-first onto the {nLDAC, MOSI, SCK, nCS} pad group.
// Define DM_DAC_SEQ_ABORT_EN to add the abort input that cuts a frame short.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | all lines idle, req_ready high, waiting for a word
// S_SETUP | nCS low, MOSI holds the MSB, one half-period before SCK
// S_SHIFT | SCK toggles every half-period, MOSI advances on falls
// S_HOLD  | SCK low, nCS held low for two half-periods, then released
// S_LDAC  | one half-period of nCS-high setup, then nLDAC low pulse
// S_GAP   | one half-period of idle lines before returning to IDLE

module dm_dac_out_sequencer #(
    parameter int WORD_BITS   = 24,
    parameter int CLKDIV      = 4,
    parameter int LDAC_HALVES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WORD_BITS-1:0] req_data,
    input  logic                 req_last,
`ifdef DM_DAC_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic [3:0]           pad_d
);

    localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS + 1) : 1;
    localparam int HALF_W = (LDAC_HALVES > 1) ? $clog2(LDAC_HALVES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(LDAC_HALVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_LDAC,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic                 last_q, last_d;
    logic                 ncs_q, ncs_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 nldac_q, nldac_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic                 tick;
    logic [WORD_BITS-1:0] sh_next;

    assign tick    = (div_q == DIV_TC);
    assign sh_next = shreg_q << 1;

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        bit_d   = bit_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        ncs_d   = ncs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        nldac_d = nldac_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (req_valid && ready_q) begin
                    state_d = S_SETUP;
                    shreg_d = req_data;
                    last_d  = req_last;
                    bit_d   = '0;
                    ncs_d   = 1'b0;
                    mosi_d  = req_data[WORD_BITS-1];
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // MOSI stays on the LSB after the final fall; HOLD clears it with nCS.
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                            half_d  = '0;
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            shreg_d = sh_next;
                            mosi_d  = sh_next[WORD_BITS-1];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (half_q == '0) begin
                        half_d = HALF_W'(1);
                    end else begin
                        half_d  = '0;
                        ncs_d   = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = last_q ? S_LDAC : S_GAP;
                    end
                end
            end
            S_LDAC: begin
                // half_q == 0 is the nCS-high setup half-period before nLDAC drops.
                if (tick) begin
                    if (half_q == '0) begin
                        nldac_d = 1'b0;
                        half_d  = HALF_W'(1);
                    end else if (half_q == HALF_LAST) begin
                        nldac_d = 1'b1;
                        half_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ncs_d   = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                nldac_d = 1'b1;
            end
        endcase

`ifdef DM_DAC_SEQ_ABORT_EN
        if (abort && (state_q == S_SETUP || state_q == S_SHIFT ||
                      state_q == S_HOLD  || state_q == S_LDAC)) begin
            state_d = S_GAP;
            div_d   = '0;
            half_d  = '0;
            ncs_d   = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
            nldac_d = 1'b1;
        end
`endif

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            ncs_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            nldac_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            nldac_q <= nldac_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign pad_d     = {nldac_q, mosi_q, sck_q, ncs_q};
    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule
